// File: rtl/acc_bias_requant_relu.sv
// Post-accumulation stage: bias add, requant shift, optional ReLU, saturation, output FIFO.
// Optional rounding (round half up) is enabled by defining ACC_REQUANT_ROUND_EN.
module acc_bias_requant_relu #(
    parameter int LANES      = 32,
    parameter int ACC_W      = 22,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [4:0]                       i_cfg_shift,
    input  logic                             i_cfg_relu_en,
    input  logic                             i_cfg_half,
    input  logic [ADDR_W-1:0]                i_bias_addr_base,
    input  logic                             i_tile_start,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [LANES*ACC_W-1:0]           i_data,
    input  logic [LANES*ACC_W-1:0]           i_bias,
    input  logic                             i_end,
    output logic [ADDR_W-1:0]                o_bias_addr,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [LANES*OUT_W-1:0]           o_data,
    output logic                             o_end,
    output logic [$clog2(FIFO_DEPTH):0]      o_fifo_count
);

    localparam int SW        = ACC_W + 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int HALF      = LANES / 2;
    localparam int SAT_MAX_I = (2 ** (OUT_W - 1)) - 1;
    localparam int SAT_MIN_I = -(2 ** (OUT_W - 1));
    localparam logic signed [SW-1:0] SAT_MAX = SW'(SAT_MAX_I);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(SAT_MIN_I);

    // The rounding increment is added in SW bits so a carry past the output range saturates.
    function automatic logic [OUT_W-1:0] requant(input logic signed [SW-1:0] s,
                                                 input logic [4:0] sh,
                                                 input logic relu);
        logic signed [SW-1:0] q;
`ifdef ACC_REQUANT_ROUND_EN
        logic [SW-1:0] mask;
        logic          rnd_bit;
`endif
        q = s >>> sh;
`ifdef ACC_REQUANT_ROUND_EN
        mask    = {{(SW-1){1'b0}}, 1'b1} << (sh - 5'd1);
        rnd_bit = (sh != 5'd0) ? (|(s & mask)) : 1'b0;
        q       = q + $signed({{(SW-1){1'b0}}, rnd_bit});
`endif
        if (relu && s[SW-1]) begin
            requant = {OUT_W{1'b0}};
        end else if (q > SAT_MAX) begin
            requant = SAT_MAX[OUT_W-1:0];
        end else if (q < SAT_MIN) begin
            requant = SAT_MIN[OUT_W-1:0];
        end else begin
            requant = q[OUT_W-1:0];
        end
    endfunction

    logic                       accept_s;
    logic [CNT_W:0]             occupancy_s;
    logic [LANES*SW-1:0]        sum_s;
    logic [LANES*OUT_W-1:0]     q2_s;
    logic                       push_s;
    logic                       pop_s;
    logic [CNT_W-1:0]           count_nxt_s;

    logic                       v1_r;
    logic [LANES*SW-1:0]        s1_r;
    logic [4:0]                 shift1_r;
    logic                       relu1_r;
    logic                       half1_r;
    logic                       end1_r;
    logic                       v2_r;
    logic [LANES*OUT_W-1:0]     d2_r;
    logic                       end2_r;
    logic [LANES*OUT_W-1:0]     mem_r [FIFO_DEPTH];
    logic                       mem_end_r [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_r;
    logic [PTR_W-1:0]           rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic                       valid_r;
    logic [ADDR_W-1:0]          addr_r;

    // Pipeline beats already accepted reserve their FIFO slot.
    assign occupancy_s = {1'b0, count_r} + (CNT_W+1)'(v1_r) + (CNT_W+1)'(v2_r);
    assign o_ready     = rst_n && (occupancy_s < (CNT_W+1)'(FIFO_DEPTH));
    assign accept_s    = i_valid && o_ready;

    // Widened bias add per lane
    always_comb begin
        sum_s = {(LANES*SW){1'b0}};
        for (int l = 0; l < LANES; l++) begin
            sum_s[l*SW +: SW] = SW'($signed(i_data[l*ACC_W +: ACC_W]))
                              + SW'($signed(i_bias[l*ACC_W +: ACC_W]));
        end
    end

    // Stage 1 register: sums and per-beat config
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r     <= 1'b0;
            s1_r     <= {(LANES*SW){1'b0}};
            shift1_r <= 5'd0;
            relu1_r  <= 1'b0;
            half1_r  <= 1'b0;
            end1_r   <= 1'b0;
        end else begin
            v1_r <= accept_s;
            if (accept_s) begin
                s1_r     <= sum_s;
                shift1_r <= i_cfg_shift;
                relu1_r  <= i_cfg_relu_en;
                half1_r  <= i_cfg_half;
                end1_r   <= i_end;
            end
        end
    end

    // Requantise each lane; upper half forced to zero in half mode
    always_comb begin
        q2_s = {(LANES*OUT_W){1'b0}};
        for (int l = 0; l < LANES; l++) begin
            if (half1_r && (l >= HALF)) begin
                q2_s[l*OUT_W +: OUT_W] = {OUT_W{1'b0}};
            end else begin
                q2_s[l*OUT_W +: OUT_W] = requant(s1_r[l*SW +: SW], shift1_r, relu1_r);
            end
        end
    end

    // Stage 2 register: requantised lanes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_r   <= 1'b0;
            d2_r   <= {(LANES*OUT_W){1'b0}};
            end2_r <= 1'b0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                d2_r   <= q2_s;
                end2_r <= end1_r;
            end
        end
    end

    assign push_s = v2_r;
    assign pop_s  = valid_r && i_ready;

    // FIFO occupancy next state
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO pointers and count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != {CNT_W{1'b0}});
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_r[wr_ptr_r]     <= d2_r;
            mem_end_r[wr_ptr_r] <= end2_r;
        end
    end

    // Bias address: tile start overrides the end-of-tile increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r <= i_bias_addr_base;
        end else if (i_tile_start) begin
            addr_r <= i_bias_addr_base;
        end else if (accept_s && i_end) begin
            addr_r <= addr_r + (i_cfg_half ? ADDR_W'(HALF) : ADDR_W'(LANES));
        end
    end

    assign o_valid      = valid_r;
    assign o_data       = valid_r ? mem_r[rd_ptr_r] : {(LANES*OUT_W){1'b0}};
    assign o_end        = valid_r ? mem_end_r[rd_ptr_r] : 1'b0;
    assign o_fifo_count = count_r;
    assign o_bias_addr  = addr_r;

endmodule

// File: doc/acc_bias_requant_relu.md
# acc_bias_requant_relu

Parametrised post-accumulation stage between the 4-way adder tree and the feature-map writeback. Per lane: adds a per-channel bias to the accumulator sum, applies a run-time arithmetic right shift with optional rounding, optional ReLU, and saturation to OUT_W bits. Results are buffered in an internal FIFO with valid/ready back-pressure. The block also advances the bias-memory address at each tile end.

## Interface
- LANES, 32, parallel output channels per beat (even, >= 2)
- ACC_W, 22, signed width of accumulator and bias lanes
- OUT_W, 8, signed output lane width (OUT_W < ACC_W)
- FIFO_DEPTH, 16, output FIFO entries (power of 2, >= 4)
- ADDR_W, 16, bias address width

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_cfg_shift  in  5  requant right-shift amount, 0..ACC_W-1; sampled every beat
- i_cfg_relu_en  in  1  1: negative results clamp to 0
- i_cfg_half  in  1  1: only lanes [LANES/2-1:0] valid; upper output lanes forced 0
- i_bias_addr_base  in  ADDR_W  bias address loaded at reset and on i_tile_start
- i_tile_start  in  1  pulse; reload address register from i_bias_addr_base
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_data  in  LANES*ACC_W  signed accumulator lanes
- i_bias  in  LANES*ACC_W  signed bias lanes, aligned with i_data
- i_end  in  1  marks the last beat of a tile; qualified by i_valid && o_ready
- o_bias_addr  out  ADDR_W  current bias address (register output)
- o_valid  out  1  FIFO head valid
- i_ready  in  1  downstream accepts head
- o_data  out  LANES*OUT_W  signed result lanes
- o_end  out  1  head beat carries tile end
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently stored

## Operation
- Accept = i_valid && o_ready. Non-accepted beats are ignored entirely (no address update).
- Stage 1 (registered): s = sext(data) + sext(bias), ACC_W+1 bits, no overflow possible. Shift/relu/half/end captured alongside.
- Stage 2 (registered): q = s >>> shift (arithmetic); rounding per Configuration; if relu_en and s < 0 -> 0; saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Rounding carry handled in ACC_W+1 bits before saturation (127.5 -> 127 for OUT_W=8). half=1 -> lanes >= LANES/2 written as 0.
- Stage 2 output written to FIFO with its end bit; pipeline never stalls, so o_ready reserves space: o_ready = (o_fifo_count + stages_in_flight) < FIFO_DEPTH, stages_in_flight in 0..2.
- Address: on accepted beat with i_end, addr += (half ? LANES/2 : LANES), wraps modulo 2^ADDR_W. i_tile_start in same cycle has priority: addr = base, increment dropped.
- FIFO: simultaneous push and pop keeps count; pop when empty impossible (o_valid=0); push when full impossible by o_ready construction.
- Reset: pipeline valids cleared, FIFO emptied, address = i_bias_addr_base. Reset mid-operation discards all in-flight and stored beats.

## Timing
- Reset values: o_valid 0, o_end 0, o_data 0, o_fifo_count 0, o_ready 0 during reset, 1 first cycle after; o_bias_addr = base.
- Beat accepted in cycle T is in FIFO at end of T+2; o_valid high in T+3 if FIFO was empty (latency 3).
- Throughput 1 beat/cycle while i_ready=1.
- o_data/o_end held stable while o_valid && !i_ready.
- o_bias_addr updates cycle after accepting end beat.

## Configuration
- ACC_REQUANT_ROUND_EN defined: round half up, q = (s >>> shift) + s[shift-1] when shift > 0; shift 0 unchanged.
- Not defined: plain truncation toward minus infinity, q = s >>> shift; rounding adder removed.

## Test plan
- data lane0=1000, bias=-40, shift=7, relu=1 -> 960>>>7=7.5 -> 8 with ROUND_EN, 7 without; latency exactly 3 cycles.
- data=-500, bias=0, relu=1 -> 0; relu=0, shift=2 -> -125; data=-100000, shift=0, relu=0 -> -128 saturation.
- data=16320, bias=0, shift=7 (127.5) -> 127 with ROUND_EN (carry saturates), no wrap to -128.
- i_ready=0 with continuous i_valid, FIFO_DEPTH=16 -> exactly 16 beats accepted, o_ready low, no loss; release i_ready -> all 16 out in order.
- base=0x0100, LANES=32: two tiles full mode then one half mode -> addr 0x0120, 0x0140, 0x0150; i_tile_start with end beat -> 0x0100.
- Reset asserted with 5 beats stored and 2 in flight -> o_valid 0, count 0 next cycle, no stale beat emitted afterward.
